// File: rtl/rt_lcd_pkg.sv
// rtl/rt_lcd_pkg.sv - shared types, LCD command/ASCII constants and message helpers
//
// Purpose: state encoding, HD44780-style command bytes, ASCII codes used by the
// result messages, default timing parameters, and helpers that pick the init
// command and the character for a given display column.
package rt_lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_CONVERT,
    ST_WR_ADDR,
    ST_WR_CHAR,
    ST_ACK,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] LCD_FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_ENTRY_MODE = 8'h06;  // increment, no shift
  localparam logic [7:0] LCD_SET_ADDR   = 8'h80;  // line 1, column 0

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_BANG    = 8'h21;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_COLON   = 8'h3A;
  localparam logic [7:0] ASCII_A       = 8'h41;
  localparam logic [7:0] ASCII_C       = 8'h43;
  localparam logic [7:0] ASCII_E       = 8'h45;
  localparam logic [7:0] ASCII_H       = 8'h48;
  localparam logic [7:0] ASCII_I       = 8'h49;
  localparam logic [7:0] ASCII_L       = 8'h4C;
  localparam logic [7:0] ASCII_M       = 8'h4D;
  localparam logic [7:0] ASCII_O       = 8'h4F;
  localparam logic [7:0] ASCII_S       = 8'h53;
  localparam logic [7:0] ASCII_T       = 8'h54;
  localparam logic [7:0] ASCII_W       = 8'h57;
  localparam logic [7:0] ASCII_LOWER_M = 8'h6D;
  localparam logic [7:0] ASCII_LOWER_S = 8'h73;

  localparam int POWERUP_CYCLES_DEF = 50;
  localparam int CMD_WAIT_DEF       = 1;
  localparam int CLEAR_WAIT_DEF     = 2;

  localparam logic [9:0] MAX_TIME = 10'd999;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = LCD_FUNC_SET;
      2'd1:    c = LCD_DISP_ON;
      2'd2:    c = LCD_CLEAR;
      default: c = LCD_ENTRY_MODE;
    endcase
    return c;
  endfunction

  // Character at display column col; cheat wins over slow, slow over the time.
  function automatic logic [7:0] msg_char(input logic cheat, input logic slow,
                                          input logic [11:0] bcd, input logic [3:0] col);
    logic [7:0] c;
    c = ASCII_SPACE;
    if (cheat) begin
      case (col)
        4'd0:    c = ASCII_C;
        4'd1:    c = ASCII_H;
        4'd2:    c = ASCII_E;
        4'd3:    c = ASCII_A;
        4'd4:    c = ASCII_T;
        4'd5:    c = ASCII_BANG;
        default: c = ASCII_SPACE;
      endcase
    end else if (slow) begin
      case (col)
        4'd0:    c = ASCII_T;
        4'd1:    c = ASCII_O;
        4'd2:    c = ASCII_O;
        4'd4:    c = ASCII_S;
        4'd5:    c = ASCII_L;
        4'd6:    c = ASCII_O;
        4'd7:    c = ASCII_W;
        default: c = ASCII_SPACE;
      endcase
    end else begin
      case (col)
        4'd0:    c = ASCII_T;
        4'd1:    c = ASCII_I;
        4'd2:    c = ASCII_M;
        4'd3:    c = ASCII_E;
        4'd4:    c = ASCII_COLON;
        4'd6:    c = ASCII_ZERO + {4'd0, bcd[11:8]};
        4'd7:    c = ASCII_ZERO + {4'd0, bcd[7:4]};
        4'd8:    c = ASCII_ZERO + {4'd0, bcd[3:0]};
        4'd10:   c = ASCII_LOWER_M;
        4'd11:   c = ASCII_LOWER_S;
        default: c = ASCII_SPACE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - iterative shift-add-3 binary to 3-digit BCD converter
//
// Purpose: converts a 10-bit value (0..999 expected) to three BCD digits.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : one-cycle pulse; i_bin is sampled on the same edge
//   i_bin          : binary input
//   o_bcd          : {hundreds, tens, ones}, valid from o_done onwards
//   o_done         : one-cycle pulse, 10 clocks after i_start
module bin2bcd (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [9:0]  i_bin,
  output logic [11:0] o_bcd,
  output logic        o_done
);

  logic [9:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [21:0] w_step;

  // One double-dabble iteration: correct digits >= 5, then shift in the next bit.
  function automatic logic [21:0] dabble(input logic [11:0] bcd, input logic [9:0] bin);
    logic [11:0] adj;
    for (int d = 0; d < 3; d++) begin
      adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
    end
    return {adj, bin} << 1;
  endfunction

  // The start edge performs the first iteration straight from i_bin, so ten
  // iterations finish exactly ten clocks after the start cycle.
  assign w_step = i_start ? dabble(12'd0, i_bin) : dabble(r_bcd, r_bin);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      {r_bcd, r_bin} <= w_step;
      r_cnt          <= 4'd9;
      r_busy         <= 1'b1;
      r_done         <= 1'b0;
    end else if (r_busy) begin
      {r_bcd, r_bin} <= w_step;
      r_cnt          <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = r_done;

endmodule

// File: rtl/lcd_display_ctrl.sv
// rtl/lcd_display_ctrl.sv - reaction-timer result display on an 8-bit character LCD
//
// Purpose: powers up and initialises the LCD, then on each timer request shows
// the latched result (cheat, too slow, or the time in ms) on line 1 and
// completes a four-phase handshake with the requester.
// Ports:
//   i_clk, i_rst_n   : 1 kHz clock, asynchronous active-low reset
//   i_reaction_time  : measured time in ms
//   i_cheat, i_slow  : result flags
//   i_lcd_update     : request (four-phase, acknowledged by o_lcd_ack)
//   o_lcd_ack        : handshake acknowledge
//   o_lcd_rs/rw/e    : LCD register select, read/write (always 0), enable
//   o_lcd_data       : LCD data bus
//   o_ready          : high only while idle
module lcd_display_ctrl
  import rt_lcd_pkg::*;
#(
  parameter int POWERUP_CYCLES = POWERUP_CYCLES_DEF,
  parameter int CMD_WAIT       = CMD_WAIT_DEF,
  parameter int CLEAR_WAIT     = CLEAR_WAIT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_reaction_time,
  input  logic       i_cheat,
  input  logic       i_slow,
  input  logic       i_lcd_update,
  output logic       o_lcd_ack,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_data,
  output logic       o_ready
);

  localparam int CW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

  // Write phase counter: 0 = SETUP, 1 = PULSE, 2 = HOLD, 3.. = post-write wait.
  localparam logic [1:0] PH_PULSE = 2'd1;
  localparam logic [7:0] LAST_PH_CMD   = 8'(2 + CMD_WAIT);
  localparam logic [7:0] LAST_PH_CLEAR = 8'(2 + CLEAR_WAIT);

  state_t      r_state;
  state_t      w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [7:0]  r_ph;
  logic [7:0]  w_ph_next;
  logic [3:0]  r_idx;
  logic [3:0]  w_idx_next;
  logic        r_cheat;
  logic        r_slow;
  logic        r_pending;
  logic        w_accept;
  logic        w_in_write;
  logic        w_wr_last;
  logic [7:0]  w_data;
  logic [7:0]  w_last_ph;
  logic [9:0]  w_bin;
  logic [11:0] w_bcd;
  logic        w_bcd_done;

  // A request seen before IDLE is remembered so it is serviced once init ends.
  assign w_accept = (r_state == ST_IDLE) && (i_lcd_update || r_pending);

  // The converter captures the (saturated) time on the accept edge and thus
  // acts as the latch for the reaction time.
  assign w_bin = (i_reaction_time > MAX_TIME) ? MAX_TIME : i_reaction_time;

  bin2bcd u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_accept),
    .i_bin   (w_bin),
    .o_bcd   (w_bcd),
    .o_done  (w_bcd_done)
  );

  // Byte presented on the bus for the write in progress.
  always_comb begin
    w_data     = 8'h00;
    w_in_write = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_data     = init_cmd(r_idx[1:0]);
        w_in_write = 1'b1;
      end
      ST_WR_ADDR: begin
        w_data     = LCD_SET_ADDR;
        w_in_write = 1'b1;
      end
      ST_WR_CHAR: begin
        w_data     = msg_char(r_cheat, r_slow, w_bcd, r_idx);
        w_in_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_last_ph = (w_data == LCD_CLEAR) ? LAST_PH_CLEAR : LAST_PH_CMD;
  assign w_wr_last = w_in_write && (r_ph == w_last_ph);

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_ph_next    = r_ph;
    w_idx_next   = r_idx;
    case (r_state)
      ST_PWR_WAIT: begin
        if (r_cnt == CW'(POWERUP_CYCLES - 1)) begin
          w_next_state = ST_INIT;
          w_cnt_next   = '0;
          w_ph_next    = '0;
          w_idx_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_INIT: begin
        if (w_wr_last) begin
          w_ph_next = '0;
          if (r_idx == 4'd3) begin
            w_next_state = ST_IDLE;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + 4'd1;
          end
        end else begin
          w_ph_next = r_ph + 8'd1;
        end
      end
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (w_bcd_done) begin
          w_next_state = ST_WR_ADDR;
          w_ph_next    = '0;
        end
      end
      ST_WR_ADDR: begin
        if (w_wr_last) begin
          w_next_state = ST_WR_CHAR;
          w_ph_next    = '0;
          w_idx_next   = '0;
        end else begin
          w_ph_next = r_ph + 8'd1;
        end
      end
      ST_WR_CHAR: begin
        if (w_wr_last) begin
          w_ph_next = '0;
          if (r_idx == 4'd15) begin
            w_next_state = ST_ACK;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + 4'd1;
          end
        end else begin
          w_ph_next = r_ph + 8'd1;
        end
      end
      ST_ACK: begin
        if (!i_lcd_update) w_next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_PWR_WAIT;
      r_cnt     <= '0;
      r_ph      <= '0;
      r_idx     <= '0;
      r_cheat   <= 1'b0;
      r_slow    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_ph    <= w_ph_next;
      r_idx   <= w_idx_next;
      if (w_accept) begin
        r_cheat   <= i_cheat;
        r_slow    <= i_slow;
        r_pending <= 1'b0;
      end else if (((r_state == ST_PWR_WAIT) || (r_state == ST_INIT)) && i_lcd_update) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign o_lcd_e    = w_in_write && (r_ph == {6'd0, PH_PULSE});
  assign o_lcd_rs   = (r_state == ST_WR_CHAR);
  assign o_lcd_data = w_data;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_ack  = (r_state == ST_ACK);
  assign o_ready    = (r_state == ST_IDLE);

endmodule

// File: tb/tb_lcd_display_ctrl.sv
// tb/tb_lcd_display_ctrl.sv - scoreboard bench for lcd_display_ctrl
module tb_lcd_display_ctrl;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rt_i = '0;
  logic       cheat_i = 1'b0;
  logic       slow_i = 1'b0;
  logic       upd = 1'b0;
  logic       o_lcd_ack, o_lcd_rs, o_lcd_rw, o_lcd_e, o_ready;
  logic [7:0] o_lcd_data;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_e_rises = 0;
  int   last_e_cyc = 0;
  exp_t q[$];

  lcd_display_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_reaction_time (rt_i),
    .i_cheat         (cheat_i),
    .i_slow          (slow_i),
    .i_lcd_update    (upd),
    .o_lcd_ack       (o_lcd_ack),
    .o_lcd_rs        (o_lcd_rs),
    .o_lcd_rw        (o_lcd_rw),
    .o_lcd_e         (o_lcd_e),
    .o_lcd_data      (o_lcd_data),
    .o_ready         (o_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every E rising edge pops one expected write; the HOLD cycle after
  // it must keep RS/DATA and have E low again.
  logic       prev_e = 1'b0;
  logic       hold_pend = 1'b0;
  logic [8:0] held = '0;
  exp_t       mon_x;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e    = 1'b0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_e_low", int'(o_lcd_e), 0);
        chk("hold_rs_data_stable", int'({o_lcd_rs, o_lcd_data}), int'(held));
        hold_pend = 1'b0;
      end
      if (o_lcd_e && !prev_e) begin
        n_e_rises++;
        last_e_cyc = cyc;
        chk("rw_low", int'(o_lcd_rw), 0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: rs=%0d data=0x%02h at cycle %0d, none expected",
                   o_lcd_rs, o_lcd_data, cyc);
        end else begin
          mon_x = q.pop_front();
          chk("write_rs_data", int'({o_lcd_rs, o_lcd_data}), int'({mon_x.rs, mon_x.data}));
          if (mon_x.cyc >= 0) chk("write_cycle", cyc, mon_x.cyc);
        end
        held      = {o_lcd_rs, o_lcd_data};
        hold_pend = 1'b1;
      end
      prev_e = o_lcd_e;
    end
  end

  // Init timing from reset release: 50 idle clocks, SETUP, then E; 4-clock
  // spacing with CMD_WAIT=1, 5 clocks after the clear (CLEAR_WAIT=2).
  task automatic push_init();
    exp_t x;
    x.rs = 1'b0;
    x.data = 8'h38; x.cyc = 51; q.push_back(x);
    x.data = 8'h0C; x.cyc = 55; q.push_back(x);
    x.data = 8'h01; x.cyc = 59; q.push_back(x);
    x.data = 8'h06; x.cyc = 64; q.push_back(x);
  endtask

  task automatic push_msg(input string s);
    exp_t x;
    x.rs = 1'b0; x.data = 8'h80; x.cyc = -1;
    q.push_back(x);
    for (int i = 0; i < 16; i++) begin
      x.rs   = 1'b1;
      x.data = (i < s.len()) ? s[i] : 8'h20;
      x.cyc  = -1;
      q.push_back(x);
    end
  endtask

  task automatic wait_ready(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (o_ready) begin
        at_cyc = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ready_timeout: Ready never rose, expected within 3000 clocks");
  endtask

  task automatic wait_ack(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (o_lcd_ack) begin
        at_cyc = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ack_timeout: LCDAck never rose, expected within 3000 clocks");
  endtask

  task automatic finish_handshake();
    int c;
    wait_ack(c);
    chk("ack_after_last_hold_wait", c - last_e_cyc, 3);
    chk("queue_drained_at_ack", q.size(), 0);
    upd = 1'b0;
    @(negedge clk); #1;
    chk("ack_low_after_release", int'(o_lcd_ack), 0);
    chk("ready_low_in_release", int'(o_ready), 0);
    @(negedge clk); #1;
    chk("ready_after_release", int'(o_ready), 1);
  endtask

  task automatic do_request(input logic [9:0] rt, input logic ch, input logic sl, input string msg);
    int t;
    wait_ready(t);
    rt_i = rt; cheat_i = ch; slow_i = sl; upd = 1'b1;
    push_msg(msg);
    @(negedge clk); #1;
    chk("ready_low_busy", int'(o_ready), 0);
    rt_i = ~rt; cheat_i = ~ch; slow_i = ~sl;
    finish_handshake();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_e"},     int'(o_lcd_e), 0);
    chk({tag, "_rs"},    int'(o_lcd_rs), 0);
    chk({tag, "_data"},  int'(o_lcd_data), 0);
    chk({tag, "_ack"},   int'(o_lcd_ack), 0);
    chk({tag, "_ready"}, int'(o_ready), 0);
    chk({tag, "_rw"},    int'(o_lcd_rw), 0);
  endtask

  initial begin
    int t;
    int base;
    bit hit;

    // Request held high from reset: serviced straight after init, once.
    rt_i = 10'd42; upd = 1'b1;
    #1;
    check_reset_outputs("reset");
    push_init();
    push_msg("TIME: 042 ms");
    @(negedge clk); #2;
    rst_n = 1'b1;
    wait_ready(t);
    chk("ready_first_cycle", t, 67);
    finish_handshake();
    chk("e_count_first_run", n_e_rises, 4 + 17);
    repeat (20) @(negedge clk);
    #1;
    chk("ready_stays_idle", int'(o_ready), 1);
    chk("no_extra_writes", n_e_rises, 4 + 17);

    do_request(10'd237,  1'b0, 1'b0, "TIME: 237 ms");
    do_request(10'd237,  1'b1, 1'b1, "CHEAT!");
    do_request(10'd500,  1'b0, 1'b1, "TOO SLOW");
    do_request(10'd1023, 1'b0, 1'b0, "TIME: 999 ms");
    do_request(10'd5,    1'b0, 1'b0, "TIME: 005 ms");
    do_request(10'd1000, 1'b0, 1'b0, "TIME: 999 ms");
    do_request(10'd999,  1'b0, 1'b0, "TIME: 999 ms");

    // Reset while character 7 is being strobed.
    wait_ready(t);
    rt_i = 10'd123; cheat_i = 1'b0; slow_i = 1'b0; upd = 1'b1;
    push_msg("TIME: 123 ms");
    base = n_e_rises;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk); #1;
      if (n_e_rises == base + 9) hit = 1'b1;
    end
    chk("reached_char7", int'(hit), 1);
    chk("e_high_before_reset", int'(o_lcd_e), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    upd = 1'b0;
    repeat (3) @(negedge clk);
    push_init();
    #2;
    rst_n = 1'b1;
    base = n_e_rises;
    wait_ready(t);
    chk("ready_after_reinit", t, 67);
    chk("e_count_reinit", n_e_rises - base, 4);

    do_request(10'd0, 1'b0, 1'b0, "TIME: 000 ms");

    repeat (5) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
